// File: rtl/tff_period_meter.sv
// ---------------------------------------------------------------------------
// tff_period_meter
//
// Measures the divided square wave coming out of the T-flip-flop divider.
// For every full period of q_in (rising edge to rising edge) it produces the
// period length and the high-phase length, both in clk cycles, and hands the
// result to a consumer through a single-entry valid/ready holding register.
//
// Parameters
//   W            width of the cycle counter and of period / high_time (W >= 2)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   q_in         divided signal, already synchronous to clk
//   en           measurement enable; low forces the FSM to IDLE
//   clr          synchronous clear: clears overrun, re-arms, drops the
//                measurement in progress
//   out_ready    consumer accepts the held result
//   period_valid output register holds an unaccepted result
//   period       cycles between two consecutive rising edges
//   high_time    cycles from a rising edge to the following falling edge
//   sat          period counter saturated during this result
//   overrun      sticky: a completed result was dropped (register was full)
//   rise_pulse   one-cycle pulse, cycle after a rising edge is detected
//   fall_pulse   one-cycle pulse, cycle after a falling edge is detected
// ---------------------------------------------------------------------------
module tff_period_meter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         q_in,
    input  logic         en,
    input  logic         clr,
    input  logic         out_ready,
    output logic         period_valid,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         sat,
    output logic         overrun,
    output logic         rise_pulse,
    output logic         fall_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2
    } state_e;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    // state
    state_e         state_q,       state_d;
    logic           q_d_q,         q_d_d;
    logic [W-1:0]   cnt_q,         cnt_d;
    logic           sat_i_q,       sat_i_d;
    logic [W-1:0]   high_lat_q,    high_lat_d;

    // output holding register
    logic           valid_q,       valid_d;
    logic [W-1:0]   period_q,      period_d;
    logic [W-1:0]   high_time_q,   high_time_d;
    logic           sat_q,         sat_d;
    logic           overrun_q,     overrun_d;
    logic           rise_pulse_q,  rise_pulse_d;
    logic           fall_pulse_q,  fall_pulse_d;

    logic           rise;
    logic           fall;
    logic           complete;
    logic           xfer;

    // Edge detection is combinational on q_in so edges are seen in the same
    // cycle q_in changes; it runs regardless of en.
    assign rise = q_in & ~q_d_q;
    assign fall = ~q_in & q_d_q;
    assign xfer = valid_q & out_ready;

    always_comb begin
        q_d_d        = q_in;
        rise_pulse_d = rise;
        fall_pulse_d = fall;

        // Free-running saturating counter; a rise restarts it at 1 so that
        // its value at the next detection equals the elapsed cycle count.
        cnt_d   = cnt_q;
        sat_i_d = sat_i_q;
        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (!rise && (cnt_d == CNT_MAX)) begin
            sat_i_d = 1'b1;
        end

        // FSM: clr dominates en, en dominates edges.
        state_d    = state_q;
        high_lat_d = high_lat_q;
        complete   = 1'b0;
        if (clr) begin
            state_d = en ? S_ARM : S_IDLE;
        end else if (!en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                end
                S_ARM: begin
                    if (rise) begin
                        state_d = S_MEAS;
                        sat_i_d = 1'b0;
                    end
                end
                S_MEAS: begin
                    if (fall) begin
                        high_lat_d = cnt_q;
                    end
                    if (rise) begin
                        complete = 1'b1;
                        sat_i_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Output register: a completion may load in the same cycle the held
        // result is being accepted; otherwise a full register drops it.
        valid_d     = valid_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        sat_d       = sat_q;
        overrun_d   = overrun_q;
        if (complete) begin
            if (!valid_q || out_ready) begin
                valid_d     = 1'b1;
                period_d    = cnt_q;
                high_time_d = high_lat_q;
                sat_d       = sat_i_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        if (clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            q_d_q        <= 1'b0;
            cnt_q        <= '0;
            sat_i_q      <= 1'b0;
            high_lat_q   <= '0;
            valid_q      <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
            sat_q        <= 1'b0;
            overrun_q    <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_d_q        <= q_d_d;
            cnt_q        <= cnt_d;
            sat_i_q      <= sat_i_d;
            high_lat_q   <= high_lat_d;
            valid_q      <= valid_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            sat_q        <= sat_d;
            overrun_q    <= overrun_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
        end
    end

    assign period_valid = valid_q;
    assign period       = period_q;
    assign high_time    = high_time_q;
    assign sat          = sat_q;
    assign overrun      = overrun_q;
    assign rise_pulse   = rise_pulse_q;
    assign fall_pulse   = fall_pulse_q;

endmodule

// File: doc/tff_period_meter.md
# tff_period_meter

Downstream consumer of the two-stage T-flip-flop divider output. Samples the divided square wave `q_in` in the same clock domain. Measures each full period and each high phase in `clk` cycles, and delivers one result per period through a valid/ready output holding register. It reports saturation and dropped results, so the divider's toggle rate can be checked in system and by the bench.

## Interface
- `W`, default 8: width of the cycle counter and of the `period` / `high_time` fields (W ≥ 2).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `q_in`  in  1  divided signal from the T-FF stage; synchronous to `clk`, so no synchronizer.
- `en`  in  1  measurement enable.
- `clr`  in  1  synchronous clear: clears `overrun`, re-arms the FSM, drops the result in progress.
- `out_ready`  in  1  consumer accepts the result.
- `period_valid`  out  1  result register holds an unaccepted result.
- `period`  out  W  cycles between two consecutive rising edges of `q_in`.
- `high_time`  out  W  cycles from a rising edge to the following falling edge.
- `sat`  out  1  the period counter saturated during this result.
- `overrun`  out  1  sticky: a completed result was dropped.
- `rise_pulse`  out  1  one-cycle pulse, the cycle after a rising edge is detected.
- `fall_pulse`  out  1  one-cycle pulse, the cycle after a falling edge is detected.

## Operation
- **Edge detection**
  - `q_d` is a registered copy of `q_in`, reset value 0.
  - Rising edge: `rise = q_in & ~q_d`. Falling edge: `fall = ~q_in & q_d`.
  - Detection is always active, independent of `en`.
- **Counter `cnt`** (W bits)
  - On `rise`: `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`, saturating at 2^W−1; reaching the maximum sets an internal `sat_i` flag.
  - So `cnt`, sampled at a detection cycle, equals the number of cycles since the previous rise.
- **FSM states**
  - IDLE: entered on reset or when `en=0`.
  - ARM: wait for the first rise.
  - MEAS: counting.
- **FSM transitions**
  - IDLE → ARM when `en=1`.
  - ARM → MEAS on `rise`; `sat_i` is cleared.
  - In MEAS on `fall`: `high_lat <= cnt`.
  - In MEAS on `rise`: a result {`cnt`, `high_lat`, `sat_i`} completes; the FSM stays in MEAS and the next period starts with `cnt <= 1` and `sat_i` cleared.
  - Any state → IDLE when `en=0`. The result in progress is discarded; the output register is retained.
  - `clr=1` takes priority over `en` and edges: FSM → ARM if `en=1`, else → IDLE; `overrun` is cleared.
- **Output register (one entry)**
  - A completed result loads when `!period_valid`, or when a transfer (`period_valid & out_ready`) occurs in the same cycle; `period_valid` is then 1.
  - A transfer with no new result clears `period_valid` on the next cycle.
  - A completed result while `period_valid & !out_ready` is dropped: the register is unchanged and `overrun <= 1`.
  - `period`, `high_time` and `sat` are stable while `period_valid=1 & out_ready=0`.
- **Saturation**
  - `period` = 2^W−1 and `sat=1` when the counter saturated.
  - `high_time` saturates the same way, since it is a copy of `cnt`.

## Timing
- **Reset values:** `period_valid`, `period`, `high_time`, `sat`, `overrun`, `rise_pulse`, `fall_pulse` are all 0; `q_d=0`, `cnt=0`, FSM in IDLE.
- **Edge detect latency:** `rise`/`fall` are seen the same cycle `q_in` changes; `rise_pulse`/`fall_pulse` assert 1 cycle later.
- **Result latency:** `period_valid` rises in the cycle after the closing rising edge is detected.
- **First period:** the first rise after arming produces no result; the first result needs two rises.
- **`q_in=1` at reset release:** counts as a rise on the first cycle (because `q_d=0`).
- **Reset mid-operation:** everything returns to reset values immediately (asynchronous); any pending result is lost.

## Test plan
- **Steady divider signal:** `en=1`, `out_ready=1`, `q_in` high 2 / low 2 (divider with `data=1`) → a valid pulse every 4 cycles with `period=4`, `high_time=2`, `sat=0`; first result only after the second rise.
- **Asymmetric waveform:** high 3 / low 5 → `period=8`, `high_time=3`; `rise_pulse`/`fall_pulse` each one cycle wide, one cycle after the edge.
- **Backpressure:** `out_ready=0` across 3 periods of 4 → the first result is held stable, `overrun=1` after the second completion. Then `out_ready=1` for 1 cycle → the first result transfers. `clr` → `overrun=0`.
- **Simultaneous transfer and completion:** `period_valid=1`, `out_ready=1` on the same cycle a new result completes → the new value loads, `period_valid` stays 1, `overrun` stays 0.
- **Saturation:** `W=4`, `q_in` rises, then stays low 20 cycles and rises again → `period=15`, `sat=1`. The next period of 4 → `sat=0`.
- **Enable and reset mid-operation:** drop `en` mid-period → no result; re-raise `en` → a result only after two more rises. Assert `rst` mid-period with `period_valid=1` → all outputs 0 immediately.
